quantizer: RTL and testbench



---
 rtl/quantizer.sv | 182 ++++++++++++++++++
 tb/tb_quantizer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/quantizer.sv
// Forward JPEG quantizer: divides one signed fixed-point DCT coefficient by its
// luminance table entry, rounds half away from zero, and saturates the result.
// A bit-serial restoring divider is used, so only one coefficient is in flight.
module quantizer #(
  parameter int Q_BIT     = 32,
  parameter int Q_FRAC    = 16,
  parameter int HDATA_BIT = 16,
  parameter int BLOCK_BIT = 3,
  parameter int TABLO_BIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [Q_BIT-1:0]     dct_veri_i,
  input  logic [BLOCK_BIT-1:0] dct_veri_row_i,
  input  logic [BLOCK_BIT-1:0] dct_veri_col_i,
  input  logic                 dct_veri_gecerli_i,
  input  logic                 dct_blok_son_i,
  output logic                 dct_veri_hazir_o,
  output logic [HDATA_BIT-1:0] zig_veri_o,
  output logic [BLOCK_BIT-1:0] zig_veri_row_o,
  output logic [BLOCK_BIT-1:0] zig_veri_col_o,
  output logic                 zig_veri_gecerli_o,
  output logic                 zig_blok_son_o,
  input  logic                 zig_veri_hazir_i
);

  // Quotient bits: |x| / (T*2^Q_FRAC) < 2^(Q_BIT-Q_FRAC), plus one for rounding.
  localparam int N      = Q_BIT - Q_FRAC + 1;
  localparam int CW     = $clog2(N);
  localparam int DW_DIV = TABLO_BIT + Q_FRAC + N - 1;
  localparam int DW     = ((DW_DIV > Q_BIT + 1) ? DW_DIV : Q_BIT + 1) + 1;
  localparam int SMAX   = 2 ** (HDATA_BIT - 1) - 1;

  // ISO/IEC 10918-1 Table K.1 luminance, row-major.
  localparam logic [7:0] QTAB [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  typedef enum logic [1:0] {BOSTA, BOL, CIKIS} state_t;

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [DW-1:0]          rem_q, rem_d;
  logic [DW-1:0]          dsh_q, dsh_d;
  logic [N-1:0]           quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BLOCK_BIT-1:0]   row_q, row_d, col_q, col_d;
  logic                   son_q, son_d;
  logic [HDATA_BIT-1:0]   zdat_q, zdat_d;
  logic [BLOCK_BIT-1:0]   zrow_q, zrow_d, zcol_q, zcol_d;
  logic                   zvld_q, zvld_d;
  logic                   zson_q, zson_d;

  logic [2*BLOCK_BIT-1:0] idx;
  logic [TABLO_BIT-1:0]   tval;
  logic [Q_BIT:0]         xext, mag;
  logic [DW-1:0]          rem_init, dsh_init;
  logic                   qbit;
  logic [N-1:0]           quo_nx;
  logic [HDATA_BIT-1:0]   sat, res;

  // Operand prep, one divider step, and sign/saturation of the final quotient.
  always_comb begin
    idx      = {dct_veri_row_i, dct_veri_col_i};
    tval     = TABLO_BIT'(QTAB[idx]);
    xext     = {dct_veri_i[Q_BIT-1], dct_veri_i};
    mag      = dct_veri_i[Q_BIT-1] ? (~xext + (Q_BIT+1)'(1)) : xext;
    // Adding half a divisor turns truncation into round-half-up on |x|.
    rem_init = DW'(mag) + (DW'(tval) << (Q_FRAC - 1));
    dsh_init = DW'(tval) << (Q_FRAC + N - 1);
    qbit     = (rem_q >= dsh_q);
    quo_nx   = {quo_q[N-2:0], qbit};
    sat      = (quo_nx > N'(SMAX)) ? HDATA_BIT'(SMAX) : HDATA_BIT'(quo_nx);
    // Negating a zero magnitude yields +0, never a negative zero pattern.
    res      = sign_q ? (~sat + HDATA_BIT'(1)) : sat;
  end

  // Next-state logic for the accept / divide / hold-output sequence.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    son_d   = son_q;
    zdat_d  = zdat_q;
    zrow_d  = zrow_q;
    zcol_d  = zcol_q;
    zvld_d  = zvld_q;
    zson_d  = zson_q;
    case (state_q)
      BOSTA: begin
        if (dct_veri_gecerli_i) begin
          state_d = BOL;
          sign_d  = dct_veri_i[Q_BIT-1];
          rem_d   = rem_init;
          dsh_d   = dsh_init;
          quo_d   = '0;
          cnt_d   = CW'(N - 1);
          row_d   = dct_veri_row_i;
          col_d   = dct_veri_col_i;
          son_d   = dct_blok_son_i;
        end
      end
      BOL: begin
        if (qbit) rem_d = rem_q - dsh_q;
        quo_d = quo_nx;
        dsh_d = dsh_q >> 1;
        if (cnt_q == '0) begin
          state_d = CIKIS;
          zdat_d  = res;
          zrow_d  = row_q;
          zcol_d  = col_q;
          zson_d  = son_q;
          zvld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CIKIS: begin
        if (zig_veri_hazir_i) begin
          zvld_d  = 1'b0;
          state_d = BOSTA;
        end
      end
      default: state_d = BOSTA;
    endcase
  end

  // State and datapath registers; reset drops any in-flight coefficient.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOSTA;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      dsh_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      son_q   <= 1'b0;
      zdat_q  <= '0;
      zrow_q  <= '0;
      zcol_q  <= '0;
      zvld_q  <= 1'b0;
      zson_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      son_q   <= son_d;
      zdat_q  <= zdat_d;
      zrow_q  <= zrow_d;
      zcol_q  <= zcol_d;
      zvld_q  <= zvld_d;
      zson_q  <= zson_d;
    end
  end

  assign dct_veri_hazir_o   = (state_q == BOSTA);
  assign zig_veri_o         = zdat_q;
  assign zig_veri_row_o     = zrow_q;
  assign zig_veri_col_o     = zcol_q;
  assign zig_veri_gecerli_o = zvld_q;
  assign zig_blok_son_o     = zson_q;

endmodule

// File: tb/tb_quantizer.sv
// Self-checking bench for quantizer: directed cases, backpressure, mid-divide
// reset, and a 64-coefficient random block against a real-arithmetic model.
module tb_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [2:0]  drow, dcol;
  logic        dvld, dson, dhaz;
  logic [15:0] zdat;
  logic [2:0]  zrow, zcol;
  logic        zvld, zson, zrdy;

  int n_chk = 0;
  int n_err = 0;

  int qtab [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  quantizer dut (
    .clk_i(clk), .rst_i(rst),
    .dct_veri_i(din), .dct_veri_row_i(drow), .dct_veri_col_i(dcol),
    .dct_veri_gecerli_i(dvld), .dct_blok_son_i(dson), .dct_veri_hazir_o(dhaz),
    .zig_veri_o(zdat), .zig_veri_row_o(zrow), .zig_veri_col_o(zcol),
    .zig_veri_gecerli_o(zvld), .zig_blok_son_o(zson), .zig_veri_hazir_i(zrdy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // round(x / 2^16 / T), half away from zero, clamped to +/-32767.
  function automatic longint model(input logic [31:0] x, input int t);
    longint xs = longint'($signed(x));
    longint a  = (xs < 0) ? -xs : xs;
    real    r  = real'(a) / 65536.0 / real'(t);
    longint q  = longint'($rtoi(r + 0.5));
    if (q > 32767) q = 32767;
    return (xs < 0) ? -q : q;
  endfunction

  // One coefficient end to end. While busy, a junk input is held valid to
  // prove it is ignored; the output is held for 'hold' cycles of no-ready.
  task automatic run_one(input logic [31:0] x, input int r, input int c,
                         input bit son, input longint exp, input int gap,
                         input int hold, input bit lat_chk, input string tag,
                         output bit got_son);
    int to;
    int e;
    got_son = 1'b0;
    repeat (gap) @(negedge clk);
    din = x; drow = r[2:0]; dcol = c[2:0]; dson = son; dvld = 1'b1;
    to = 0;
    while (!dhaz && to < 100) begin @(negedge clk); to++; end
    chk({tag, ":accept"}, longint'(to < 100), 1);
    @(negedge clk);
    din = 32'h7fff_ffff; drow = 3'd5; dcol = 3'd2; dson = 1'b1;
    e = 0;
    while (!zvld && e < 60) begin @(negedge clk); e++; end
    if (lat_chk) chk({tag, ":latency"}, e, 17);
    chk({tag, ":data"}, longint'($signed(zdat)), exp);
    chk({tag, ":row"}, zrow, r);
    chk({tag, ":col"}, zcol, c);
    chk({tag, ":son"}, zson, son);
    got_son = zson;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":hold_vld"}, zvld, 1);
      chk({tag, ":hold_data"}, longint'($signed(zdat)), exp);
      chk({tag, ":hold_rdy"}, dhaz, 0);
    end
    zrdy = 1'b1;
    @(negedge clk);
    zrdy = 1'b0;
    dvld = 1'b0;
    chk({tag, ":post_vld"}, zvld, 0);
    chk({tag, ":post_rdy"}, dhaz, 1);
  endtask

  initial begin
    bit     s;
    bit     seen;
    int     son_cnt;
    int     son_idx;
    logic [31:0] x;
    int     t;
    rst = 1'b1; din = '0; drow = '0; dcol = '0; dvld = 1'b0; dson = 1'b0;
    zrdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", dhaz, 1);
    chk("rst_vld", zvld, 0);
    chk("rst_data", zdat, 0);
    chk("rst_tags", {zrow, zcol, zson}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_one(32'd6553600, 0, 0, 1'b0, 6, 0, 0, 1'b1, "p100", s);
    run_one(-32'sd6586368, 0, 1, 1'b0, -9, 1, 0, 1'b1, "m100_5", s);
    run_one(32'd524288, 0, 0, 1'b0, 1, 0, 0, 1'b1, "p8_half", s);
    run_one(-32'sd524288, 0, 0, 1'b0, -1, 0, 1, 1'b1, "m8_half", s);
    run_one(32'd19464192, 7, 7, 1'b1, 3, 0, 0, 1'b1, "p297_son", s);
    run_one(32'd0, 3, 4, 1'b0, 0, 2, 0, 1'b1, "zero", s);
    run_one(32'h8000_0000, 0, 0, 1'b0, -2048, 0, 0, 1'b1, "minneg", s);
    run_one(32'd7143424, 4, 5, 1'b0, 1, 0, 0, 1'b1, "t109", s);
    run_one(32'd6488064, 7, 7, 1'b0, 1, 0, 5, 1'b1, "bkpr", s);

    // Reset in the middle of a divide: nothing from that coefficient appears.
    din = 32'd6553600; drow = 3'd0; dcol = 3'd0; dson = 1'b1; dvld = 1'b1;
    while (!dhaz) @(negedge clk);
    @(negedge clk);
    dvld = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdy", dhaz, 1);
    chk("mrst_vld", zvld, 0);
    chk("mrst_data", zdat, 0);
    chk("mrst_tags", {zrow, zcol, zson}, 0);
    seen = 1'b0;
    repeat (25) begin @(negedge clk); if (zvld) seen = 1'b1; end
    chk("mrst_stale", seen, 0);
    run_one(-32'sd1048576, 1, 0, 1'b0, -1, 0, 0, 1'b1, "after_rst", s);

    // Random 64-coefficient block in zigzag-agnostic row-major order.
    son_cnt = 0;
    son_idx = -1;
    for (int i = 0; i < 64; i++) begin
      t = qtab[i];
      case ($urandom_range(0, 3))
        0: x = $urandom();
        1: x = 32'($signed($urandom_range(0, 2 * 2048 * 65536)) - 2048 * 65536);
        2: begin
          x = 32'(($urandom_range(0, 200) * 2 + 1) * t * 32768);
          if ($urandom_range(0, 1) == 1) x = -x;
        end
        default: x = 32'($signed($urandom_range(0, 2000)) - 1000);
      endcase
      run_one(x, i / 8, i % 8, (i == 63), model(x, t), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'b1, $sformatf("rnd%0d", i), s);
      if (s) begin son_cnt++; son_idx = i; end
    end
    chk("son_count", son_cnt, 1);
    chk("son_index", son_idx, 63);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
